apb_xfer_ctrl: RTL and testbench

//  Single-outstanding APB transfer sequencer for the AHB-Lite to APB bridge.

---
 rtl/apb_xfer_ctrl.sv | 129 ++++++++++++
 tb/tb_apb_xfer_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_xfer_ctrl.sv
// Single-outstanding APB transfer sequencer: one valid/ready request in,
// SETUP/ACCESS phases with wait states and timeout abort, one response beat out.
module apb_xfer_ctrl #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned TOUT_CYC = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          psel,
    output logic          penable,
    output logic          pwrite,
    output logic [AW-1:0] paddr,
    output logic [DW-1:0] pwdata,
    input  logic [DW-1:0] prdata,
    input  logic          pready,
    input  logic          pslverr
);

    localparam int unsigned CW = (TOUT_CYC > 0) ? $clog2(TOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    state_e          state_q;
    logic            req_ready_q;
    logic            rsp_valid_q;
    logic [DW-1:0]   rsp_rdata_q;
    logic            rsp_err_q;
    logic            psel_q;
    logic            penable_q;
    logic            pwrite_q;
    logic [AW-1:0]   paddr_q;
    logic [DW-1:0]   pwdata_q;
    logic [CW-1:0]   wait_cnt_q;
    logic            timeout_c;

    // Abort fires on the edge that would complete the TOUT_CYC-th stalled ACCESS cycle
    assign timeout_c = (TOUT_CYC != 0) && (wait_cnt_q == CW'(TOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            wait_cnt_q  <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        state_q     <= SETUP;
                        req_ready_q <= 1'b0;
                        psel_q      <= 1'b1;
                        pwrite_q    <= req_write;
                        paddr_q     <= req_addr;
                        pwdata_q    <= req_write ? req_wdata : '0;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                SETUP: begin
                    state_q    <= ACCESS;
                    penable_q  <= 1'b1;
                    wait_cnt_q <= '0;
                end
                ACCESS: begin
                    if (pready) begin
                        state_q     <= RESP;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= pwrite_q ? '0 : prdata;
                        rsp_err_q   <= pslverr;
                    end else if (timeout_c) begin
                        state_q     <= RESP;
                        psel_q      <= 1'b0;
                        penable_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b1;
                    end else if (TOUT_CYC != 0) begin
                        wait_cnt_q <= wait_cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b0;
                    psel_q      <= 1'b0;
                    penable_q   <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_xfer_ctrl.sv
// Directed bench for apb_xfer_ctrl: table-driven transfers plus reset,
// timeout and back-to-back request sequences.
module tb_apb_xfer_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_cmp = 0;
    int n_err = 0;

    apb_xfer_ctrl #(.AW(32), .DW(32), .TOUT_CYC(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // waits = ACCESS cycles with pready=0 before pready=1; acc = expected ACCESS cycles
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int unsigned waits;
        logic [31:0] prd;
        logic        slv;
        int unsigned acc;
        logic [31:0] e_rdata;
        logic        e_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at a negedge where req_ready is high
    task automatic wait_ready();
        int i;
        for (i = 0; i < 20; i++) begin
            if (req_ready === 1'b1) break;
            @(negedge clk);
        end
        n_cmp++;
        if (i >= 20) begin
            n_err++;
            $display("FAIL wait_ready: got req_ready=%b expected 1 within 20 cycles", req_ready);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        wait_ready();
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h5A5A_5A5A;
        req_write = ~v.wr;
        for (int k = 1; k <= int'(v.acc) + 3; k++) begin
            @(negedge clk);
            pready  = (k == int'(v.waits) + 2);
            prdata  = (k == int'(v.waits) + 2) ? v.prd : 32'hBAD0_0000;
            pslverr = (k == int'(v.waits) + 2) ? v.slv : 1'b1;
            if (k == 1) begin
                chk($sformatf("v%0d_setup_psel", idx), 32'(psel), 32'd1);
                chk($sformatf("v%0d_setup_pen", idx), 32'(penable), 32'd0);
                chk($sformatf("v%0d_setup_rdy", idx), 32'(req_ready), 32'd0);
            end else if (k <= int'(v.acc) + 1) begin
                chk($sformatf("v%0d_acc%0d_psel", idx, k), 32'(psel), 32'd1);
                chk($sformatf("v%0d_acc%0d_pen", idx, k), 32'(penable), 32'd1);
                chk($sformatf("v%0d_acc%0d_rv", idx, k), 32'(rsp_valid), 32'd0);
            end else if (k == int'(v.acc) + 2) begin
                chk($sformatf("v%0d_resp_rv", idx), 32'(rsp_valid), 32'd1);
                chk($sformatf("v%0d_resp_psel", idx), 32'(psel), 32'd0);
                chk($sformatf("v%0d_resp_pen", idx), 32'(penable), 32'd0);
                chk($sformatf("v%0d_resp_rdata", idx), rsp_rdata, v.e_rdata);
                chk($sformatf("v%0d_resp_err", idx), 32'(rsp_err), 32'(v.e_err));
                chk($sformatf("v%0d_paddr", idx), paddr, v.addr);
                chk($sformatf("v%0d_pwrite", idx), 32'(pwrite), 32'(v.wr));
                chk($sformatf("v%0d_pwdata", idx), pwdata, v.wr ? v.wdata : 32'h0);
                chk($sformatf("v%0d_resp_rdy", idx), 32'(req_ready), 32'd0);
            end else begin
                chk($sformatf("v%0d_post_rv", idx), 32'(rsp_valid), 32'd0);
                chk($sformatf("v%0d_post_rdy", idx), 32'(req_ready), 32'd1);
                chk($sformatf("v%0d_post_rdata", idx), rsp_rdata, v.e_rdata);
                chk($sformatf("v%0d_post_err", idx), 32'(rsp_err), 32'(v.e_err));
            end
        end
        pready  = 1'b0;
        pslverr = 1'b0;
    endtask

    initial begin
        int          rsp_cnt;
        int          acc_cyc[3];
        int          aidx;
        logic        rdy;
        logic [31:0] exp_paddr;
        logic [31:0] addrs[3];

        //            wr    addr          wdata          waits prd            slv   acc e_rdata        e_err
        vecs[0] = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 0,  32'h0,         1'b0, 1, 32'h0,         1'b0};
        vecs[1] = '{1'b0, 32'h0000_0080, 32'h0,         3,  32'h1234_5678, 1'b0, 4, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b0, 32'h0000_00C0, 32'h0,         0,  32'hAAAA_5555, 1'b1, 1, 32'hAAAA_5555, 1'b1};
        vecs[3] = '{1'b0, 32'h0000_0100, 32'h0,         10, 32'h7777_7777, 1'b0, 4, 32'h0,         1'b1};
        vecs[4] = '{1'b0, 32'h0000_0104, 32'h0,         3,  32'h0BAD_F00D, 1'b0, 4, 32'h0BAD_F00D, 1'b0};
        vecs[5] = '{1'b1, 32'h0000_0200, 32'h1122_3344, 1,  32'hCCCC_CCCC, 1'b1, 2, 32'h0,         1'b1};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        prdata    = 32'h0;
        pready    = 1'b0;
        pslverr   = 1'b0;

        // Reset state and first-edge req_ready
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_psel", 32'(psel), 32'd0);
        chk("rst_penable", 32'(penable), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_paddr", paddr, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rel_req_ready_low", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("rel_req_ready_high", 32'(req_ready), 32'd1);

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Reset asserted mid-ACCESS
        wait_ready();
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0300;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("t5_in_access", 32'(penable), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_psel", 32'(psel), 32'd0);
        chk("t5_penable", 32'(penable), 32'd0);
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t5_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t5_rel_ready_low", 32'(req_ready), 32'd0);
        rsp_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) chk("t5_rel_ready_high", 32'(req_ready), 32'd1);
            if (rsp_valid === 1'b1) rsp_cnt++;
        end
        chk("t5_no_rsp", 32'(rsp_cnt), 32'd0);

        // req_valid held high across three requests; fields change while not ready
        addrs[0]  = 32'h0000_1000;
        addrs[1]  = 32'h0000_2000;
        addrs[2]  = 32'h0000_3000;
        exp_paddr = 32'h0;
        aidx      = 0;
        rsp_cnt   = 0;
        acc_cyc   = '{0, 0, 0};
        pready    = 1'b1;
        pslverr   = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (cyc > 0) @(negedge clk);
            chk($sformatf("t6_paddr_c%0d", cyc), paddr, exp_paddr);
            if (rsp_valid === 1'b1) rsp_cnt++;
            rdy = req_ready;
            if (aidx < 3) begin
                req_addr = rdy ? addrs[aidx] : $urandom;
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk);
            if (rdy && req_valid) begin
                exp_paddr     = addrs[aidx];
                acc_cyc[aidx] = cyc;
                aidx++;
            end
        end
        chk("t6_accepts", 32'(aidx), 32'd3);
        chk("t6_gap01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd4);
        chk("t6_gap12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd4);
        chk("t6_rsp_cnt", 32'(rsp_cnt), 32'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
